// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, state encoding and request-decode helpers
// for the lsu_mem_if load/store initiator.
// The optional misalignment check is enabled by defining LSU_MISALIGN_CHK_EN.
package lsu_pkg;

    // RISC-V load/store width codes (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte write-enable masks, lane 0 = lowest byte address
    localparam logic [3:0] WEN_B = 4'b0001;
    localparam logic [3:0] WEN_H = 4'b0011;
    localparam logic [3:0] WEN_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Codes 011, 110, 111 are never legal; unsigned widths make no sense for stores.
    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
               (we && funct3[2]);
    endfunction

    // Store mask selected by the width part of funct3 (low two bits).
    function automatic logic [3:0] store_mask(input logic [2:0] funct3);
        logic [3:0] m;
        case (funct3[1:0])
            2'b00:   m = WEN_B;
            2'b01:   m = WEN_H;
            default: m = WEN_W;
        endcase
        return m;
    endfunction

    // Halfwords need addr[0] = 0, words need addr[1:0] = 00.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic m;
        case (funct3[1:0])
            2'b01:   m = addr_lo[0];
            2'b10:   m = (addr_lo != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: combinational sign/zero extension of raw SRAM read data
// according to the load width code.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    // Select and extend the low byte/halfword; words pass through.
    always_comb begin
        data = raw;
        case (funct3)
            F3_B:    data = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   data = {24'h000000, raw[7:0]};
            F3_H:    data = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   data = {16'h0000, raw[15:0]};
            F3_W:    data = raw;
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: single-outstanding load/store initiator between the CPU memory
// stage and a byte-addressed SRAM with combinational read.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload until that edge, and ready may not depend
// combinationally on valid (both ready and valid here are registered).
// Optional: define LSU_MISALIGN_CHK_EN to reject misaligned H/HU/W accesses.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [3:0]    mem_w_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    lsu_state_t  state;
    lsu_state_t  next_state;

    logic        accept;
    logic        req_err;
    logic        we_q;
    logic [2:0]  f3_q;
    logic        err_q;
    logic [31:0] ext_data;

    assign accept = (state == IDLE) && req_valid && req_ready;

    // Classify the incoming request; misalignment only counts when checking is built in.
    always_comb begin
        req_err = f3_illegal(req_we, req_funct3);
`ifdef LSU_MISALIGN_CHK_EN
        if (misaligned(req_funct3, req_addr[1:0])) begin
            req_err = 1'b1;
        end
`endif
    end

    // Next-state logic: one ACCESS cycle, then RESP until the consumer takes it.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register plus registered handshake flags derived from the next state.
    // req_ready resets low and rises one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= next_state;
            req_ready <= (next_state == IDLE);
            rsp_valid <= (next_state == RESP);
        end
    end

    lsu_load_ext u_load_ext (
        .funct3 (f3_q),
        .raw    (mem_rdata),
        .data   (ext_data)
    );

    // Request capture, SRAM port drive and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            err_q     <= 1'b0;
            mem_w_en  <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q      <= req_we;
                f3_q      <= req_funct3;
                err_q     <= req_err;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
                mem_w_en  <= (req_we && !req_err) ? store_mask(req_funct3) : 4'b0000;
            end else begin
                // Write enable is only ever live for the single ACCESS cycle.
                mem_w_en <= 4'b0000;
            end
            if (state == ACCESS) begin
                rsp_err   <= err_q;
                rsp_rdata <= (!we_q && !err_q) ? ext_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: bench for lsu_mem_if with a byte-array SRAM model and a
// byte-level reference model of load/store semantics.
// Honours LSU_MISALIGN_CHK_EN the same way as the design.
module tb_lsu_mem_if;
    import lsu_pkg::*;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [3:0]    mem_w_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    lsu_mem_if #(.AW(AW), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // ---------------- SRAM model ----------------
    logic [7:0] sram [0:65535];
    logic       mem_loaded = 1'b0;

    always_comb begin
        mem_rdata = {sram[16'(mem_addr + 16'd3)], sram[16'(mem_addr + 16'd2)],
                     sram[16'(mem_addr + 16'd1)], sram[mem_addr]};
    end

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 65536; i++) sram[i] <= 8'(i * 7 + 3);
            mem_loaded <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mem_w_en[i]) sram[16'(mem_addr + 16'(i))] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:65535];

    function automatic void ref_exec(input logic we, input logic [2:0] f3,
                                     input logic [15:0] addr, input logic [31:0] wdata,
                                     output logic [31:0] rdata, output logic err,
                                     output logic [3:0] wen);
        int nbytes;
        logic illegal;
        logic [31:0] raw;
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
        case (f3[1:0])
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            default: nbytes = 4;
        endcase
        err = illegal;
`ifdef LSU_MISALIGN_CHK_EN
        if ((int'(addr) % nbytes) != 0) err = 1'b1;
`endif
        rdata = 32'h0;
        wen   = 4'h0;
        if (err) return;
        if (we) begin
            wen = 4'((1 << nbytes) - 1);
            for (int i = 0; i < nbytes; i++) ref_mem[16'(addr + 16'(i))] = wdata[8*i +: 8];
        end else begin
            raw = 32'h0;
            for (int i = 0; i < nbytes; i++) raw = raw | (32'(ref_mem[16'(addr + 16'(i))]) << (8*i));
            if (!f3[2] && nbytes < 4 && raw[8*nbytes-1]) raw = raw | (32'hFFFF_FFFF << (8*nbytes));
            rdata = raw;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [15:0] addr, input logic [31:0] wdata, input int hold);
        logic [31:0] e_rdata;
        logic        e_err;
        logic [3:0]  e_wen;
        int          n;
        ref_exec(we, f3, addr, wdata, e_rdata, e_err, e_wen);
        exp_q.push_back(e_rdata);
        n = 0;
        while (!req_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready_wait"}, 32'(n < 10), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_wdata  = $urandom;
        // ACCESS cycle
        check({tag, "_acc_wen"},   32'(mem_w_en), 32'(e_wen));
        check({tag, "_acc_addr"},  32'(mem_addr), 32'(addr));
        check({tag, "_acc_wdata"}, mem_wdata, wdata);
        check({tag, "_acc_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_acc_valid"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        // RESP, held for 'hold' extra cycles with rsp_ready low
        e_rdata = exp_q.pop_front();
        for (int c = 0; c <= hold; c++) begin
            check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_rsp_rdata"}, rsp_rdata, e_rdata);
            check({tag, "_rsp_err"},   32'(rsp_err), 32'(e_err));
            check({tag, "_rsp_wen"},   32'(mem_w_en), 32'd0);
            check({tag, "_rsp_ready"}, 32'(req_ready), 32'd0);
            if (c < hold) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        check("rst_mem_w_en",  32'(mem_w_en), 32'd0);
        check("rst_mem_addr",  32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_ready_high", 32'(req_ready), 32'd1);

        // Directed scenarios
        do_req("sw10",  1'b1, F3_W,  16'h0010, 32'hDEADBEEF, 0);
        do_req("lw10",  1'b0, F3_W,  16'h0010, 32'h0, 0);
        do_req("sb21",  1'b1, F3_B,  16'h0021, 32'h000000F0, 0);
        do_req("lb21",  1'b0, F3_B,  16'h0021, 32'h0, 0);
        do_req("lbu21", 1'b0, F3_BU, 16'h0021, 32'h0, 0);
        do_req("lw20",  1'b0, F3_W,  16'h0020, 32'h0, 0);
        do_req("sh30",  1'b1, F3_H,  16'h0030, 32'h00008001, 0);
        do_req("lh30",  1'b0, F3_H,  16'h0030, 32'h0, 5);
        do_req("lhu30", 1'b0, F3_HU, 16'h0030, 32'h0, 0);
        do_req("sill",  1'b1, 3'b100, 16'h0050, 32'hCAFEF00D, 0);
        do_req("lw50",  1'b0, F3_W,  16'h0050, 32'h0, 0);
        do_req("lill",  1'b0, 3'b111, 16'h0050, 32'h0, 0);
        do_req("l011",  1'b0, 3'b011, 16'h0050, 32'h0, 1);

        // Reset during ACCESS aborts a store
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 16'h0040;
        req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstacc_wen_live", 32'(mem_w_en), 32'hF);
        rst_n = 1'b0;
        #1;
        check("rstacc_wen_clear", 32'(mem_w_en), 32'd0);
        check("rstacc_ready",     32'(req_ready), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rstacc_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstacc_rel_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("rstacc_rel_high", 32'(req_ready), 32'd1);
        check("rstacc_rel_rsp",  32'(rsp_valid), 32'd0);
        do_req("lw40", 1'b0, F3_W, 16'h0040, 32'h0, 0);

        // Misaligned word load and wrapping store
        do_req("lw13",   1'b0, F3_W, 16'h0013, 32'h0, 0);
        do_req("swfffe", 1'b1, F3_W, 16'hFFFE, 32'h44332211, 0);
        do_req("lb0000", 1'b0, F3_BU, 16'h0000, 32'h0, 0);
        do_req("lb0001", 1'b0, F3_BU, 16'h0001, 32'h0, 0);
        do_req("lwfffc", 1'b0, F3_W, 16'hFFFC, 32'h0, 0);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 7) == 0) a = 16'hFFFC + 16'($urandom_range(0, 3));
            else                           a = 16'h0100 + 16'($urandom_range(0, 31));
            do_req($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   a, $urandom, $urandom_range(0, 3));
        end

        // Final sweep of the randomized window via word loads
        for (int k = 0; k < 8; k++) begin
            do_req($sformatf("sweep%0d", k), 1'b0, F3_W, 16'h0100 + 16'(4 * k), 32'h0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
